// File: rtl/stepdir_decoder.sv
// stepdir_decoder: synchronizes and de-glitches external step/dir lines and tracks a signed position.
// Build option: define STEPDIR_PERIOD_EN to add the step-period measurement.
module stepdir_decoder #(
    parameter int POS_W      = 32,
    parameter int FILTER_LEN = 3,
    parameter int SETUP_CYC  = 4,
    parameter int PERIOD_W   = 24
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                step_i,
    input  logic                dir_i,
    input  logic                enable,
    input  logic                pos_load,
    input  logic [POS_W-1:0]    pos_load_val,
    input  logic                err_clr,
    output logic [POS_W-1:0]    position,
    output logic                step_evt,
    output logic                step_dir,
    output logic                err_setup,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);
    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int AGE_W  = $clog2(SETUP_CYC + 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [AGE_W-1:0]  AGE_MAX   = AGE_W'(SETUP_CYC);

    // Bit 0 carries the step line, bit 1 the dir line.
    logic [1:0]        r_sync1;
    logic [1:0]        r_sync2;
    logic [1:0]        r_filt;
    logic [FCNT_W-1:0] r_fcnt [2];
    logic [1:0]        w_flip;
    logic              r_step_f_d;
    logic [1:0]        r_vld;
    logic              r_armed;
    logic [AGE_W-1:0]  r_dir_age;
    logic              w_evt;
    logic              w_setup_viol;

    logic [POS_W-1:0]  r_position;
    logic              r_step_evt;
    logic              r_step_dir;
    logic              r_err_setup;

    assign w_flip[0]    = (r_sync2[0] != r_filt[0]) && (r_fcnt[0] == FCNT_LAST);
    assign w_flip[1]    = (r_sync2[1] != r_filt[1]) && (r_fcnt[1] == FCNT_LAST);
    assign w_evt        = r_filt[0] && !r_step_f_d && r_armed;
    assign w_setup_viol = w_evt && (r_dir_age < AGE_MAX);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_filt     <= '0;
            r_fcnt[0]  <= '0;
            r_fcnt[1]  <= '0;
            r_step_f_d <= 1'b0;
            r_vld      <= '0;
            r_armed    <= 1'b0;
            r_dir_age  <= AGE_MAX;
        end else begin
            r_sync1    <= {dir_i, step_i};
            r_sync2    <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FCNT_W'(1);
                end
            end
            r_step_f_d <= r_filt[0];
            // Edges are ignored until a genuine low has been seen on step after reset,
            // so a line held high through reset release is never counted.
            r_vld <= {r_vld[0], 1'b1};
            if (r_vld[1] && !r_sync2[0]) begin
                r_armed <= 1'b1;
            end
            if (w_flip[1]) begin
                r_dir_age <= '0;
            end else if (r_dir_age != AGE_MAX) begin
                r_dir_age <= r_dir_age + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_position  <= '0;
            r_step_evt  <= 1'b0;
            r_step_dir  <= 1'b0;
            r_err_setup <= 1'b0;
        end else begin
            r_step_evt <= w_evt;
            if (w_evt) begin
                r_step_dir <= r_filt[1];
            end
            if (pos_load) begin
                r_position <= pos_load_val;
            end else if (w_evt && enable) begin
                r_position <= r_filt[1] ? r_position + POS_W'(1) : r_position - POS_W'(1);
            end
            if (w_setup_viol) begin
                r_err_setup <= 1'b1;
            end else if (err_clr) begin
                r_err_setup <= 1'b0;
            end
        end
    end

    assign position  = r_position;
    assign step_evt  = r_step_evt;
    assign step_dir  = r_step_dir;
    assign err_setup = r_err_setup;

`ifdef STEPDIR_PERIOD_EN
    localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;

    logic [PERIOD_W-1:0] r_pcnt;
    logic [PERIOD_W-1:0] r_period;
    logic                r_evt_seen;
    logic                r_period_valid;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_pcnt         <= '0;
            r_period       <= '0;
            r_evt_seen     <= 1'b0;
            r_period_valid <= 1'b0;
        end else if (w_evt) begin
            r_period   <= (r_pcnt == PCNT_MAX) ? PCNT_MAX : r_pcnt + PERIOD_W'(1);
            r_pcnt     <= '0;
            r_evt_seen <= 1'b1;
            if (r_evt_seen) begin
                r_period_valid <= 1'b1;
            end
        end else if (r_pcnt != PCNT_MAX) begin
            r_pcnt <= r_pcnt + PERIOD_W'(1);
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stepdir_decoder.sv
// tb_stepdir_decoder: directed and randomized checks of stepdir_decoder against a sample-history model.
module tb_stepdir_decoder;
    localparam int POS_W = 32;
    localparam int FL    = 3;
    localparam int SC    = 4;
    localparam int PW    = 24;

    logic             sys_clk = 1'b0;
    logic             sys_rst, step_i, dir_i, enable, pos_load, err_clr;
    logic [POS_W-1:0] pos_load_val;
    logic [POS_W-1:0] position;
    logic             step_evt, step_dir, err_setup, period_valid;
    logic [PW-1:0]    period;

    stepdir_decoder #(.POS_W(POS_W), .FILTER_LEN(FL), .SETUP_CYC(SC), .PERIOD_W(PW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .step_i(step_i), .dir_i(dir_i),
        .enable(enable), .pos_load(pos_load), .pos_load_val(pos_load_val), .err_clr(err_clr),
        .position(position), .step_evt(step_evt), .step_dir(step_dir), .err_setup(err_setup),
        .period(period), .period_valid(period_valid)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;
    int dut_evts = 0;

    // Model: filtered value = last value that FL consecutive synchronized samples agreed on;
    // synchronized sample seen at edge k is the pad value taken at edge k-2.
    int               k = 0;
    bit               hs[$];
    bit               hd[$];
    bit               fs1, fs2, fd1;
    int               last_dir_chg, first_low, last_ref, n_evt;
    logic [POS_W-1:0] m_pos;
    bit               m_evt, m_dir, m_err, m_pvalid;
    logic [PW-1:0]    m_period;

    function automatic bit win(input bit h[$], input bit prev);
        bit v;
        v = h[2];
        for (int i = 3; i <= FL + 1; i++)
            if (h[i] != v) return prev;
        return v;
    endfunction

    task automatic model_reset();
        hs.delete(); hd.delete();
        for (int i = 0; i < FL + 2; i++) begin hs.push_back(1'b0); hd.push_back(1'b0); end
        fs1 = 0; fs2 = 0; fd1 = 0;
        last_dir_chg = -1000; first_low = -1; last_ref = k; n_evt = 0;
        m_pos = '0; m_evt = 0; m_dir = 0; m_err = 0; m_pvalid = 0; m_period = '0;
    endtask

    task automatic tick();
        bit evt, viol, nfs, nfd;
        int gap;
        @(posedge sys_clk);
        k++;
        if (!sys_rst) begin
            model_reset();
        end else begin
            evt  = fs1 && !fs2 && (first_low >= 0) && (first_low <= k - 3);
            viol = (k - 1 - last_dir_chg) < SC;
            m_evt = evt;
            if (evt) begin
                m_dir = fd1;
`ifdef STEPDIR_PERIOD_EN
                gap = k - last_ref;
                m_period = (gap > (1 << PW) - 1) ? '1 : PW'(gap);
                if (n_evt >= 1) m_pvalid = 1;
`endif
                last_ref = k;
                n_evt++;
            end
            if (pos_load) m_pos = pos_load_val;
            else if (evt && enable) m_pos = fd1 ? m_pos + 1 : m_pos - 1;
            if (evt && viol) m_err = 1;
            else if (err_clr) m_err = 0;
            hs.push_front(step_i); void'(hs.pop_back());
            hd.push_front(dir_i);  void'(hd.pop_back());
            if (!step_i && first_low < 0) first_low = k;
            nfs = win(hs, fs1);
            nfd = win(hd, fd1);
            if (nfd != fd1) last_dir_chg = k;
            fs2 = fs1; fs1 = nfs; fd1 = nfd;
        end
        @(negedge sys_clk);
        if (step_evt === 1'b1) dut_evts++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int hi, input int lo);
        step_i = 1; ticks(hi);
        step_i = 0; ticks(lo);
    endtask

    task automatic test_reset();
        sys_rst = 0; step_i = 0; dir_i = 0; enable = 0; pos_load = 0; err_clr = 0; pos_load_val = '0;
        ticks(3);
        checks++; if (position !== '0) begin failures++; $display("FAIL rst_pos got=%0h exp=0", position); end
        checks++; if (step_evt !== 1'b0) begin failures++; $display("FAIL rst_evt got=%0b exp=0", step_evt); end
        checks++; if (step_dir !== 1'b0) begin failures++; $display("FAIL rst_dir got=%0b exp=0", step_dir); end
        checks++; if (err_setup !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err_setup); end
        checks++; if (period !== '0) begin failures++; $display("FAIL rst_period got=%0h exp=0", period); end
        checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL rst_pvalid got=%0b exp=0", period_valid); end
        sys_rst = 1;
        ticks(2);
    endtask

    task automatic test_steps();
        int lat;
        dir_i = 1; enable = 1;
        ticks(20);
        dut_evts = 0;
        lat = -1;
        for (int p = 0; p < 5; p++) begin
            step_i = 1;
            for (int c = 1; c <= 10; c++) begin
                tick();
                if (p == 0 && lat < 0 && step_evt === 1'b1) lat = c;
                checks++;
                if (step_evt !== m_evt) begin failures++; $display("FAIL steps_evt k=%0d got=%0b exp=%0b", k, step_evt, m_evt); end
            end
            step_i = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                checks++;
                if (step_evt !== m_evt) begin failures++; $display("FAIL steps_evt k=%0d got=%0b exp=%0b", k, step_evt, m_evt); end
            end
        end
        checks++; if (lat != 6) begin failures++; $display("FAIL steps_latency got=%0d exp=6", lat); end
        checks++; if (dut_evts != 5) begin failures++; $display("FAIL steps_count got=%0d exp=5", dut_evts); end
        checks++; if (position !== 32'd5) begin failures++; $display("FAIL steps_pos got=%0h exp=5", position); end
        checks++; if (step_dir !== 1'b1) begin failures++; $display("FAIL steps_dir got=%0b exp=1", step_dir); end
        checks++; if (err_setup !== 1'b0) begin failures++; $display("FAIL steps_err got=%0b exp=0", err_setup); end
    endtask

    task automatic test_glitch();
        logic [POS_W-1:0] p0;
        p0 = m_pos;
        dut_evts = 0;
        step_i = 1; ticks(2);
        step_i = 0; ticks(10);
        dir_i = 0; ticks(1);
        dir_i = 1; ticks(10);
        checks++; if (dut_evts != 0) begin failures++; $display("FAIL glitch_evt got=%0d exp=0", dut_evts); end
        checks++; if (position !== p0) begin failures++; $display("FAIL glitch_pos got=%0h exp=%0h", position, p0); end
        // A clean step afterwards proves dir_f never moved: still up, no setup violation.
        pulse(10, 10);
        checks++; if (position !== p0 + 1) begin failures++; $display("FAIL glitch_after_pos got=%0h exp=%0h", position, p0 + 1); end
        checks++; if (step_dir !== 1'b1) begin failures++; $display("FAIL glitch_dir got=%0b exp=1", step_dir); end
        checks++; if (err_setup !== 1'b0) begin failures++; $display("FAIL glitch_err got=%0b exp=0", err_setup); end
    endtask

    task automatic test_setup();
        logic [POS_W-1:0] p0;
        p0 = m_pos;
        dir_i = 0; ticks(2);
        pulse(10, 10);
        checks++; if (err_setup !== 1'b1) begin failures++; $display("FAIL setup_err got=%0b exp=1", err_setup); end
        checks++; if (position !== p0 - 1) begin failures++; $display("FAIL setup_pos got=%0h exp=%0h", position, p0 - 1); end
        err_clr = 1; tick(); err_clr = 0;
        checks++; if (err_setup !== 1'b0) begin failures++; $display("FAIL setup_clr got=%0b exp=0", err_setup); end
        // Exactly SETUP_CYC of dir stability is legal.
        dir_i = 1; ticks(4);
        pulse(10, 10);
        checks++; if (err_setup !== 1'b0) begin failures++; $display("FAIL setup_edge_err got=%0b exp=0", err_setup); end
        checks++; if (position !== p0) begin failures++; $display("FAIL setup_edge_pos got=%0h exp=%0h", position, p0); end
    endtask

    task automatic test_load_wrap();
        step_i = 1; ticks(5);
        pos_load = 1; pos_load_val = 32'h7FFF_FFFF; tick(); pos_load = 0;
        checks++; if (step_evt !== 1'b1) begin failures++; $display("FAIL load_evt got=%0b exp=1", step_evt); end
        checks++; if (position !== 32'h7FFF_FFFF) begin failures++; $display("FAIL load_pos got=%0h exp=7fffffff", position); end
        ticks(4);
        step_i = 0; ticks(10);
        pulse(10, 10);
        checks++; if (position !== 32'h8000_0000) begin failures++; $display("FAIL wrap_up got=%0h exp=80000000", position); end
        pos_load = 1; pos_load_val = '0; tick(); pos_load = 0;
        dir_i = 0; ticks(10);
        pulse(10, 10);
        checks++; if (position !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_down got=%0h exp=ffffffff", position); end
    endtask

    task automatic test_period();
        int n;
        sys_rst = 0; ticks(2); sys_rst = 1;
        dir_i = 1; ticks(15);
        n = 0;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 20; c++) begin
                step_i = (c < 10);
                tick();
                if (step_evt === 1'b1) begin
                    n++;
`ifdef STEPDIR_PERIOD_EN
                    checks++;
                    if (period_valid !== (n >= 2)) begin failures++; $display("FAIL period_valid n=%0d got=%0b exp=%0b", n, period_valid, n >= 2); end
                    if (n >= 2) begin
                        checks++;
                        if (period !== PW'(20)) begin failures++; $display("FAIL period_val n=%0d got=%0d exp=20", n, period); end
                    end
`else
                    checks++;
                    if (period !== '0 || period_valid !== 1'b0) begin failures++; $display("FAIL period_off got=%0d/%0b exp=0/0", period, period_valid); end
`endif
                end
                checks++;
                if (period !== m_period || period_valid !== m_pvalid) begin
                    failures++; $display("FAIL period_model k=%0d got=%0d/%0b exp=%0d/%0b", k, period, period_valid, m_period, m_pvalid);
                end
            end
        end
        step_i = 0;
        checks++; if (n != 5) begin failures++; $display("FAIL period_count got=%0d exp=5", n); end
    endtask

    task automatic test_reset_mid();
        sys_rst = 0; ticks(2); sys_rst = 1;
        step_i = 0; dir_i = 1; enable = 1; ticks(15);
        dir_i = 0; ticks(2);
        pulse(10, 10);
        dir_i = 1; ticks(12);
        for (int p = 0; p < 4; p++) pulse(10, 10);
        checks++; if (position !== 32'd3 || err_setup !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%0h/%0b exp=3/1", position, err_setup); end
        step_i = 1; ticks(3);
        sys_rst = 0; tick();
        checks++;
        if (position !== '0 || step_evt !== 1'b0 || step_dir !== 1'b0 || err_setup !== 1'b0 || period !== '0 || period_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_outs got=%0h/%0b/%0b/%0b/%0h/%0b exp=all 0", position, step_evt, step_dir, err_setup, period, period_valid);
        end
        ticks(2);
        sys_rst = 1;
        dut_evts = 0;
        ticks(20);
        checks++; if (dut_evts != 0) begin failures++; $display("FAIL midrst_held got=%0d exp=0", dut_evts); end
        step_i = 0; ticks(10);
        pulse(10, 10);
        checks++; if (dut_evts != 1) begin failures++; $display("FAIL midrst_rearm got=%0d exp=1", dut_evts); end
        checks++; if (position !== 32'd1) begin failures++; $display("FAIL midrst_pos got=%0h exp=1", position); end
    endtask

    task automatic test_random();
        int srun = 0;
        int drun = 0;
        for (int c = 0; c < 4000; c++) begin
            if (srun == 0) begin step_i = ~step_i; srun = $urandom_range(1, 8); end
            if (drun == 0) begin dir_i = ~dir_i; drun = $urandom_range(1, 24); end
            srun--; drun--;
            enable       = ($urandom_range(0, 9) != 0);
            pos_load     = ($urandom_range(0, 39) == 0);
            pos_load_val = $urandom;
            err_clr      = ($urandom_range(0, 19) == 0);
            sys_rst      = ($urandom_range(0, 799) != 0);
            tick();
            checks++; if (position !== m_pos) begin failures++; $display("FAIL rnd_pos k=%0d got=%0h exp=%0h", k, position, m_pos); end
            checks++; if (step_evt !== m_evt) begin failures++; $display("FAIL rnd_evt k=%0d got=%0b exp=%0b", k, step_evt, m_evt); end
            checks++; if (step_dir !== m_dir) begin failures++; $display("FAIL rnd_dir k=%0d got=%0b exp=%0b", k, step_dir, m_dir); end
            checks++; if (err_setup !== m_err) begin failures++; $display("FAIL rnd_err k=%0d got=%0b exp=%0b", k, err_setup, m_err); end
            checks++; if (period !== m_period) begin failures++; $display("FAIL rnd_period k=%0d got=%0h exp=%0h", k, period, m_period); end
            checks++; if (period_valid !== m_pvalid) begin failures++; $display("FAIL rnd_pvalid k=%0d got=%0b exp=%0b", k, period_valid, m_pvalid); end
        end
        pos_load = 0; err_clr = 0; sys_rst = 1;
    endtask

    initial begin
        test_reset();
        test_steps();
        test_glitch();
        test_setup();
        test_load_wrap();
        test_period();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stepdir_decoder.md
Name: stepdir_decoder

Overview:
Receive-side counterpart of the stepper step/dir generator. Samples external step/dir lines, removes glitches, and tracks a signed position counter. Also flags dir-to-step setup violations and optionally measures the step period. Sits beside the stepper channels in the motion top, with its status and control registers exposed on the Wishbone CSR bus. Intended uses are encoder-style loopback checking of our own stepper outputs and following an external motion controller.

Parameters:
POS_W, 32, width of the position counter (two's complement).
FILTER_LEN, 3, number of consecutive stable cycles before a synchronized input is accepted (must be >= 1).
SETUP_CYC, 4, minimum cycles the filtered dir must be stable before a step rising edge.
PERIOD_W, 24, width of the step period measurement.

Ports:
sys_clk  input  1  system clock; all logic is on this single clock.
sys_rst  input  1  synchronous reset, active-low (0 = reset).
step_i  input  1  asynchronous step input pad.
dir_i  input  1  asynchronous dir input pad; 1 = count up.
enable  input  1  1 = update position on steps.
pos_load  input  1  1-cycle strobe; loads pos_load_val into position.
pos_load_val  input  POS_W  value loaded by pos_load.
err_clr  input  1  1-cycle strobe; clears err_setup.
position  output  POS_W  current position.
step_evt  output  1  1-cycle pulse for each accepted step rising edge.
step_dir  output  1  filtered dir value captured at the last step_evt.
err_setup  output  1  sticky flag for a dir setup violation.
period  output  PERIOD_W  sys_clk cycles between the last two step edges.
period_valid  output  1  period holds a real measurement.

Behaviour:
- Reset (sys_rst=0 at a clock edge): all outputs 0; synchronizers, filters, counters and the internal step_f/dir_f state go to 0; dir_age goes to SETUP_CYC. Reset applied mid-pulse aborts all state; a step_i held high through reset release is not counted.
- Synchronizer: 2 flops on each of step_i and dir_i.
- Filter, applied independently to step and dir:
  - Per-input counter of cycles in which the synchronized value differs from the filtered value.
  - The counter clears whenever the two agree.
  - Once the counter reaches FILTER_LEN, the filtered value takes the synchronized value and the counter clears.
  - Any pulse shorter than FILTER_LEN cycles is rejected.
- Latency: step_i rise to step_evt is exactly 2+FILTER_LEN+1 cycles (6 at defaults).
- dir_age counter:
  - Cleared to 0 on the cycle dir_f changes.
  - Otherwise increments, saturating at SETUP_CYC.
- Step edge (step_f rising), registered, in that cycle:
  - step_evt=1 and step_dir<=dir_f.
  - If enable=1 and pos_load=0: position <= position+1 when dir_f=1, position-1 when dir_f=0, using modulo 2^POS_W wrap.
  - If dir_age < SETUP_CYC: err_setup<=1. The step is still counted using the current dir_f.
- enable=0: position frozen. step_evt, step_dir, err_setup and period continue to operate.
- Priorities:
  - pos_load beats a same-cycle step: position=pos_load_val and that step is not counted, though step_evt still pulses.
  - A setup-violation set beats a same-cycle err_clr.
- Falling edges of step_f have no effect.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
STEPDIR_PERIOD_EN defined:
- Counter pcnt (PERIOD_W bits) increments each cycle, saturating at all-ones.
- On each step edge: period<=pcnt+1 (saturating), then pcnt<=0.
- period_valid is set on the second step edge after reset and stays set until reset.
- If pcnt is saturated, period reads all-ones.

STEPDIR_PERIOD_EN undefined:
- No counter logic is built.
- period is tied to 0 and period_valid to 0.

Test Plan:
1. Defaults, dir_i=1 held 20 cycles, enable=1, then 5 step_i pulses (10 cycles high / 10 low) -> 5 step_evt pulses, the first 6 cycles after the first rise; position=5; step_dir=1; err_setup=0.
2. FILTER_LEN=3, step_i high for 2 cycles only, then a single 1-cycle dir_i glitch -> no step_evt, position unchanged, dir_f unchanged.
3. dir_i stable high, then dir_i falls 2 cycles before step_i rises (filtered gap 2 < SETUP_CYC=4) -> err_setup=1, position decrements by 1; pulsing err_clr then gives err_setup=0.
4. pos_load=1 with pos_load_val=0x7FFFFFFF in the same cycle as a step edge -> position=0x7FFFFFFF, step_evt=1. A following up-step gives position=0x80000000 (wrap); a down-step from 0 gives 0xFFFFFFFF.
5. With STEPDIR_PERIOD_EN, step_i rises every 20 cycles -> period_valid=0 after the first step_evt; period=20 and period_valid=1 from the second onward. Without the macro -> period=0 and period_valid=0 throughout.
6. Assert sys_rst=0 mid-sequence with position=3 and err_setup=1 -> next cycle all outputs are 0. After release with step_i held high, no step_evt occurs until step_i falls and rises again.
